fpu_issue_queue: RTL and testbench

- Upstream stage of in_rvfpm. Buffers FP instructions arriving from the core, together with their integer-register operand and memory load data.
- Assigns each accepted instruction a rolling transaction id.
- Issues one instruction per cycle into the FPU (enable / instruction / id / data_fromXreg / data_fromMem) whenever the FPU signals fpu_ready.
- Decouples core issue timing from FPU pipeline stalls.

---
 rtl/fpu_issue_queue_if.sv | 30 +++
 rtl/fpu_issue_queue.sv | 71 +++++++
 tb/tb_fpu_issue_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_queue_if.sv
// fpu_issue_queue_if: core-side and FPU-side signals of the FP issue queue
interface fpu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN = 32,
  parameter int FLEN = 32
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_xdata;
  logic [FLEN-1:0] in_mdata;
  logic fpu_ready;
  logic out_enable;
  logic [31:0] out_instr;
  logic [X_ID_WIDTH-1:0] out_id;
  logic [XLEN-1:0] out_xdata;
  logic [FLEN-1:0] out_mdata;
  logic [$clog2(DEPTH):0] count;
  logic illegal_instr;
  modport master (
    output flush, in_valid, in_instr, in_xdata, in_mdata, fpu_ready,
    input in_ready, out_enable, out_instr, out_id, out_xdata, out_mdata, count, illegal_instr
  );
  modport slave (
    input flush, in_valid, in_instr, in_xdata, in_mdata, fpu_ready,
    output in_ready, out_enable, out_instr, out_id, out_xdata, out_mdata, count, illegal_instr
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: FIFO buffering FP instructions with rolling ids ahead of the FPU; ISSUEQ_OPCODE_FILTER_EN drops non-FP opcodes
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN = 32,
  parameter int FLEN = 32
) (
  input logic ck,
  input logic rst,
  fpu_issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [31:0] instr;
    logic [XLEN-1:0] xdata;
    logic [FLEN-1:0] mdata;
    logic [X_ID_WIDTH-1:0] id;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic [X_ID_WIDTH-1:0] id_ctr;
  logic accept, push, pop, empty;
  assign empty = (cnt == '0);
  assign q.count = cnt;
  assign q.in_ready = (cnt < FULL);
  assign q.out_enable = !empty && q.fpu_ready;
  assign pop = q.out_enable;
  assign accept = q.in_valid && q.in_ready && !q.flush;
`ifdef ISSUEQ_OPCODE_FILTER_EN
  logic legal, illegal_q;
  assign legal = q.in_instr[6:0] inside {7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
                                         7'b1001011, 7'b1001111, 7'b1010011};
  assign push = accept && legal;
  assign q.illegal_instr = illegal_q;
  always_ff @(posedge ck)
    if (rst) illegal_q <= 1'b0;
    else illegal_q <= accept && !legal;
`else
  assign push = accept;
  assign q.illegal_instr = 1'b0;
`endif
  assign head = mem[rd_ptr];
  assign q.out_instr = empty ? '0 : head.instr;
  assign q.out_xdata = empty ? '0 : head.xdata;
  assign q.out_mdata = empty ? '0 : head.mdata;
  assign q.out_id = empty ? '0 : head.id;
  always_ff @(posedge ck)
    if (push) mem[wr_ptr] <= '{q.in_instr, q.in_xdata, q.in_mdata, id_ctr};
  // flush keeps id_ctr so ids remain unique across a queue clear
  always_ff @(posedge ck)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      id_ctr <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_ctr <= id_ctr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: directed plan plus randomized traffic against a queue-based reference model
module tb_fpu_issue_queue;
  localparam int DEPTH = 4;
  logic ck = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] x;
    logic [31:0] m;
    int id;
  } ent_t;
  ent_t mq[$];
  int m_id = 0;
  bit m_ill = 0;
  fpu_issue_queue_if #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .XLEN(32), .FLEN(32)) bus ();
  fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .XLEN(32), .FLEN(32)) dut (
    .ck(ck), .rst(rst), .q(bus)
  );
  always #5 ck = ~ck;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit is_fp(logic [31:0] ins);
`ifdef ISSUEQ_OPCODE_FILTER_EN
    logic [6:0] op = ins[6:0];
    return op == 7'h07 || op == 7'h27 || op == 7'h43 || op == 7'h47 ||
           op == 7'h4B || op == 7'h4F || op == 7'h53;
`else
    return ins == ins;
`endif
  endfunction
  task automatic drive(bit v, logic [31:0] ins, logic [31:0] x, logic [31:0] m,
                       bit fr, bit fl, bit r);
    ent_t h;
    @(negedge ck);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_xdata = x;
    bus.in_mdata = m;
    bus.fpu_ready = fr;
    bus.flush = fl;
    rst = r;
    #1;
    h = '{0, 0, 0, 0};
    if (mq.size() != 0) h = mq[0];
    check("count", 64'(bus.count), 64'(mq.size()));
    check("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    check("out_enable", 64'(bus.out_enable), 64'(mq.size() != 0 && fr));
    check("out_instr", 64'(bus.out_instr), 64'(h.instr));
    check("out_xdata", 64'(bus.out_xdata), 64'(h.x));
    check("out_mdata", 64'(bus.out_mdata), 64'(h.m));
    check("out_id", 64'(bus.out_id), 64'(h.id));
    check("illegal", 64'(bus.illegal_instr), 64'(m_ill));
  endtask
  task automatic tick();
    bit acc;
    @(posedge ck);
    if (rst) begin
      mq.delete();
      m_id = 0;
      m_ill = 0;
      return;
    end
    m_ill = 0;
    if (bus.flush) begin
      mq.delete();
      return;
    end
    acc = bus.in_valid && mq.size() < DEPTH;
    if (mq.size() != 0 && bus.fpu_ready) void'(mq.pop_front());
    if (acc) begin
      if (is_fp(bus.in_instr)) begin
        mq.push_back('{bus.in_instr, bus.in_xdata, bus.in_mdata, m_id});
        m_id = (m_id + 1) % 16;
      end else m_ill = 1;
    end
  endtask
  task automatic step(bit v, logic [31:0] ins, bit fr, bit fl);
    drive(v, ins, $urandom, $urandom, fr, fl, 0);
    tick();
  endtask
  initial begin
    logic [31:0] plan [4] = '{32'h00002107, 32'h002081D3, 32'h0001A1A7, 32'h00002087};
    logic [6:0] ops [8] = '{7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53, 7'h33};
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 32'h00002087, 0, 32'h3FD9999A, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("t1_en", 64'(bus.out_enable), 1);
    check("t1_instr", 64'(bus.out_instr), 64'h2087);
    check("t1_id", 64'(bus.out_id), 0);
    check("t1_mdata", 64'(bus.out_mdata), 64'h3FD9999A);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("t1_count", 64'(bus.count), 0);
    tick();
    for (int i = 0; i < 4; i++) step(1, plan[i], 0, 0);
    drive(1, 32'h00002087, 0, 0, 0, 0, 0);
    check("t2_ready", 64'(bus.in_ready), 0);
    check("t2_count", 64'(bus.count), 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check("t2_instr", 64'(bus.out_instr), 64'(plan[i]));
      check("t2_id", 64'(bus.out_id), 64'(i + 1));
      tick();
    end
    step(1, 32'h00002107, 0, 0);
    step(1, 32'h002081D3, 0, 0);
    step(1, 32'h0001A1A7, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t3_count", 64'(bus.count), 2);
    check("t3_id", 64'(bus.out_id), 6);
    tick();
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h00002087, $urandom, $urandom, 1, 0, 0);
      if (i > 0) check("t4_id", 64'(bus.out_id), 64'((i - 1) % 16));
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    check("t4_last", 64'(bus.out_id), 3);
    tick();
    for (int i = 0; i < 3; i++) step(1, 32'h00002087, 0, 0);
    drive(1, 32'h00002107, 0, 0, 0, 1, 0);
    check("t5_count3", 64'(bus.count), 3);
    tick();
    step(1, 32'h00002107, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    check("t5_count1", 64'(bus.count), 1);
    check("t5_id", 64'(bus.out_id), 7);
    tick();
`ifdef ISSUEQ_OPCODE_FILTER_EN
    step(1, 32'h00000033, 1, 0);
    drive(1, 32'h00002087, 0, 0, 1, 0, 0);
    check("t6_ill", 64'(bus.illegal_instr), 1);
    check("t6_count", 64'(bus.count), 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("t6_ill_off", 64'(bus.illegal_instr), 0);
    check("t6_id", 64'(bus.out_id), 8);
    tick();
`endif
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
      tick();
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
